seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Recovers BCD digits from a multiplexed, active-low 7-segment display bus: the reverse direction of the BCD-to-segment encoder that drives the board's HEX displays. It samples the segment and digit-select lines, requires each pattern to be stable before accepting it, and decodes it back to a 4-bit value with per-digit valid and error flags. It sits on the observation side of the display path, for self-check and loopback of display drivers.

## Interface

Parameters:
- `NDIG`, default 4: number of multiplexed digits.
- `STABLE`, default 3: consecutive identical samples required before a commit. Legal range is 1 or more.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `hex`, in, 7: segment lines, active-low. Bit 0 is segment a, bit 6 is segment g.
- `an`, in, NDIG: digit selects, active-low. Exactly one low bit means a digit is addressed.
- `clr_err`, in, 1: clears all `err` bits.
- `digits`, out, 4*NDIG: decoded BCD values. Digit k occupies `[4k+3:4k]`.
- `valid`, out, NDIG: digit k currently holds a decoded numeral.
- `err`, out, NDIG: sticky flag; digit k received an undecodable pattern.
- `upd`, out, 1: one-cycle pulse when any `digits` or `valid` bit changed.

## Operation

- **Input stage:** `{an, hex}` is registered every edge into a sample register `s`. A second register `p` holds the previous `s`.
- **Stability counter** `cnt`, width `$clog2(STABLE+1)`:
  - If the new sample equals `p`, `cnt` increments and saturates at STABLE.
  - Otherwise `cnt` loads 1.
- **Commit:** fires on the edge where `cnt` becomes STABLE, and only if `an` in `s` is one-hot-low. A run gives exactly one commit; a held pattern never re-commits.
- **Decode codes** (gfedcba):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9.
  - 1111111 is blank.
  - Every other code is invalid.
- **Commit actions for selected digit k:**
  - Numeral: `digits[k]` takes the value and `valid[k]` is set.
  - Blank: `valid[k]` clears and `digits[k]` is held.
  - Invalid: `err[k]` is set; `digits[k]` and `valid[k]` are held.
- **Ignored `an` values:** `an` all-high (inter-digit blanking) or with more than one low bit never commits and never flags an error. The counter still runs on these samples.
- **`upd`:** asserted for one cycle, registered together with the commit, only if `digits[k]` or `valid[k]` actually changed.
- **`clr_err`:** clears every `err` bit on the next edge. If a set for digit k happens on the same edge, the set wins for that bit.
- **Reset values:**
  - `digits` = 0, `valid` = 0, `err` = 0, `upd` = 0.
  - `s` and `p` = all-ones, `cnt` = 0.
  - Reset mid-run discards any partial stability count.

## Timing

- A pattern first sampled at edge n commits at edge n+STABLE-1.
- Outputs are visible after that edge. For STABLE=3, a pattern present before edge 1 appears on `digits` after edge 3.
- Minimum dwell for a digit to be captured is STABLE cycles. Shorter dwells are filtered as glitches.
- Any change in `an` or `hex` restarts stability counting.
- Outputs are fully registered, with no combinational path from inputs to outputs.
- `upd` is high for exactly one cycle per changing commit.

## Structure

- **Package `seg7_pkg`:**
  - Constants `SEG_0` through `SEG_9` and `SEG_BLANK`, shared with the encoder side so both ends use one table.
  - Enum `seg_class_t`: `NUMERAL`, `BLANK`, `INVALID`.
- **Sub-module `seg7_decode`:** combinational. Maps 7 bits to `{seg_class_t, value[3:0]}`, and is instantiated once on `s`.
- **Top:** sample registers, stability counter, one-hot check, per-digit registers, and the `upd`/`err` logic.

## Test plan

- **Reset:** reset held 2 cycles with random inputs → `digits` = 0, `valid` = 0, `err` = 0, `upd` = 0.
- **Single capture:** `an` = 1110, `hex` = 0100100, held 5 cycles → `digits[3:0]` = 2 and `valid` = 0001 after the 3rd edge; `upd` pulses once.
- **Full scan:** digits 0–3 scanned with 1, 2, 3, 4, each held 4 cycles, with 1 cycle of `an` = 1111 between digits → `digits` = 16'h4321, `valid` = 1111, `upd` pulses 4 times.
- **Glitch filter:** `an` = 1101, `hex` = 0011001 held 2 cycles, then `an` = 1111 → no change and no `upd`. A second identical scan of that digit → no extra `upd`.
- **Error handling:** `an` = 1101, `hex` = 0101010 held 3 cycles → `err` = 0010 with `digits` unchanged. Then `clr_err` asserted on the same edge as a new invalid commit on digit 1 → `err[1]` stays 1. `clr_err` alone → `err` = 0.
- **Blank and reset mid-run:** blank 1111111 committed on digit 2 → `valid[2]` = 0 with `digits[11:8]` held. `reset` pulsed after 2 stable cycles of a numeral → no commit and all outputs 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment code table (active-low, gfedcba) and decode result types.
// Both the encoder and this decoder take their segment codes from here.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        NUMERAL,
        BLANK,
        INVALID
    } seg_class_t;

    typedef struct packed {
        seg_class_t cls;
        logic [3:0] value;
    } seg_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern classifier: numeral (with BCD value), blank,
// or invalid. Value is zero for anything that is not a numeral.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec.cls   = NUMERAL;
        dec.value = 4'd0;
        case (seg)
            SEG_0:     dec.value = 4'd0;
            SEG_1:     dec.value = 4'd1;
            SEG_2:     dec.value = 4'd2;
            SEG_3:     dec.value = 4'd3;
            SEG_4:     dec.value = 4'd4;
            SEG_5:     dec.value = 4'd5;
            SEG_6:     dec.value = 4'd6;
            SEG_7:     dec.value = 4'd7;
            SEG_8:     dec.value = 4'd8;
            SEG_9:     dec.value = 4'd9;
            SEG_BLANK: dec.cls   = BLANK;
            default:   dec.cls   = INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus, accepting a
// pattern only after it has been sampled STABLE times in a row.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          hex,
    input  logic [NDIG-1:0]     an,
    input  logic                clr_err,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     valid,
    output logic [NDIG-1:0]     err,
    output logic                upd
);

    localparam int SW = NDIG + 7;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SW-1:0]          s_q, s_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   match;
    logic                   commit;
    seg_dec_t               dec;
    logic [NDIG-1:0]        sel;
    logic [NDIG-1:0][3:0]   digits_q, digits_d;
    logic [NDIG-1:0]        valid_q, valid_d;
    logic [NDIG-1:0]        err_q, err_d;
    logic [NDIG-1:0]        chg;
    logic                   upd_q, upd_d;

    // s_q already holds the previous sample, so comparing the incoming sample
    // against it is the "new s equals p" test one edge early, with no lag.
    assign s_d = {an, hex};

    always_comb begin
        match = (s_d == s_q);
        cnt_d = CNT_ONE;
        if (match) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        end
        commit = (cnt_d == CNT_MAX) && !(match && (cnt_q == CNT_MAX)) && (|sel);
    end

    seg7_decode u_decode (
        .seg (s_d[6:0]),
        .dec (dec)
    );

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] dig_n;
            logic       val_n;
            logic       err_n;

            assign sel[gi] = (s_d[SW-1:7] == ~(NDIG'(1) << gi));

            always_comb begin
                dig_n = digits_q[gi];
                val_n = valid_q[gi];
                err_n = clr_err ? 1'b0 : err_q[gi];
                if (commit && sel[gi]) begin
                    case (dec.cls)
                        NUMERAL: begin
                            dig_n = dec.value;
                            val_n = 1'b1;
                        end
                        BLANK:   val_n = 1'b0;
                        default: err_n = 1'b1;
                    endcase
                end
            end

            assign digits_d[gi] = dig_n;
            assign valid_d[gi]  = val_n;
            assign err_d[gi]    = err_n;
            assign chg[gi]      = (dig_n != digits_q[gi]) || (val_n != valid_q[gi]);
        end
    endgenerate

    assign upd_d = |chg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q      <= '1;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
        end
    end

    assign digits = digits_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign upd    = upd_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scan traffic,
// every cycle compared against a run-length based reference model.
module tb_seg7_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  hex_i;
    logic [3:0]  an_i;
    logic        clr_i;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        upd;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;

    // active-low gfedcba codes for 0..9
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    // reference model state
    logic [10:0] m_last;
    int          m_run;
    logic [15:0] m_dig;
    logic [3:0]  m_val;
    logic [3:0]  m_err;
    logic        m_upd;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .hex     (hex_i),
        .an      (an_i),
        .clr_err (clr_i),
        .digits  (digits),
        .valid   (valid),
        .err     (err),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pattern commits when its run of identical samples reaches STABLE.
    always @(posedge clk) begin
        logic [10:0] cur;
        logic [15:0] od;
        logic [3:0]  ov;
        logic [3:0]  setm;
        int zeros;
        int k;
        int v;
        cur = {an_i, hex_i};
        if (reset) begin
            m_last = '1;
            m_run  = 0;
            m_dig  = '0;
            m_val  = '0;
            m_err  = '0;
            m_upd  = 1'b0;
        end else begin
            if (cur == m_last) begin
                if (m_run <= STABLE) m_run++;
            end else begin
                m_run = 1;
            end
            m_last = cur;
            od   = m_dig;
            ov   = m_val;
            setm = '0;
            if (m_run == STABLE) begin
                zeros = 0;
                k = 0;
                for (int i = 0; i < NDIG; i++) begin
                    if (!an_i[i]) begin
                        zeros++;
                        k = i;
                    end
                end
                if (zeros == 1) begin
                    v = -1;
                    for (int j = 0; j < 10; j++) if (hex_i == tab[j]) v = j;
                    if (v >= 0) begin
                        m_dig[4*k +: 4] = 4'(v);
                        m_val[k] = 1'b1;
                    end else if (hex_i == 7'h7F) begin
                        m_val[k] = 1'b0;
                    end else begin
                        setm[k] = 1'b1;
                    end
                end
            end
            m_err = (clr_i ? 4'b0 : m_err) | setm;
            m_upd = (m_dig != od) || (m_val != ov);
        end
    end

    always @(negedge clk) begin
        chk("cyc_digits", 32'(digits), 32'(m_dig));
        chk("cyc_valid",  32'(valid),  32'(m_val));
        chk("cyc_err",    32'(err),    32'(m_err));
        chk("cyc_upd",    32'(upd),    32'(m_upd));
    end

    // Apply inputs at a negedge and hold them for n clock edges, counting upd pulses.
    task automatic drive(input logic [3:0] a, input logic [6:0] h, input logic c,
                         input logic r, input int n);
        an_i  = a;
        hex_i = h;
        clr_i = c;
        reset = r;
        $display("txn an=%b hex=%b clr=%b rst=%b cycles=%0d", a, h, c, r, n);
        repeat (n) begin
            @(negedge clk);
            if (upd === 1'b1) upd_cnt++;
        end
    endtask

    initial begin
        int u0;
        int n;
        logic [3:0] a;
        logic [6:0] h;
        reset = 1'b1;
        clr_i = 1'b0;
        an_i  = 4'($urandom);
        hex_i = 7'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_err",    32'(err),    32'h0);
        chk("rst_upd",    32'(upd),    32'h0);

        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);

        // single capture: visible after the 3rd edge, not before
        u0 = upd_cnt;
        drive(4'b1110, tab[2], 1'b0, 1'b0, 2);
        chk("cap_early_valid", 32'(valid), 32'h0);
        drive(4'b1110, tab[2], 1'b0, 1'b0, 1);
        chk("cap_digit0", 32'(digits[3:0]), 32'h2);
        chk("cap_valid",  32'(valid), 32'b0001);
        drive(4'b1110, tab[2], 1'b0, 1'b0, 2);
        chk("cap_upd_pulses", 32'(upd_cnt - u0), 32'd1);

        // full scan 1,2,3,4
        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);
        u0 = upd_cnt;
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), tab[d+1], 1'b0, 1'b0, 4);
            drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);
        end
        chk("scan_digits", 32'(digits), 32'h4321);
        chk("scan_valid",  32'(valid),  32'hF);
        chk("scan_upd_pulses", 32'(upd_cnt - u0), 32'd4);

        // glitch filter, then an unchanged rescan
        u0 = upd_cnt;
        drive(4'b1101, tab[4], 1'b0, 1'b0, 2);
        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);
        chk("glitch_digits", 32'(digits), 32'h4321);
        drive(4'b1101, tab[2], 1'b0, 1'b0, 4);
        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);
        chk("glitch_upd_pulses", 32'(upd_cnt - u0), 32'd0);

        // error handling
        drive(4'b1101, 7'h2A, 1'b0, 1'b0, 3);
        chk("err_set",    32'(err),    32'b0010);
        chk("err_digits", 32'(digits), 32'h4321);
        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);
        drive(4'b1101, 7'h2A, 1'b0, 1'b0, 2);
        drive(4'b1101, 7'h2A, 1'b1, 1'b0, 1);
        chk("err_set_wins", 32'(err), 32'b0010);
        drive(4'b1111, 7'h7F, 1'b1, 1'b0, 1);
        chk("err_cleared", 32'(err), 32'h0);

        // blank on digit 2
        drive(4'b1011, 7'h7F, 1'b0, 1'b0, 3);
        chk("blank_valid",  32'(valid), 32'b1011);
        chk("blank_digit2", 32'(digits[11:8]), 32'h3);

        // reset mid-run discards the partial count
        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);
        drive(4'b1110, tab[9], 1'b0, 1'b0, 2);
        drive(4'b1110, tab[9], 1'b0, 1'b1, 1);
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_valid",  32'(valid),  32'h0);
        chk("midrst_upd",    32'(upd),    32'h0);
        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 1);

        // randomized scan traffic
        for (int t = 0; t < 600; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = ~(4'b0001 << $urandom_range(0, 3));
                6, 7:             a = 4'b1111;
                default:          a = 4'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: h = tab[$urandom_range(0, 9)];
                7:                   h = 7'h7F;
                default:             h = 7'($urandom);
            endcase
            n = $urandom_range(1, 5);
            drive(a, h, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0), n);
        end

        drive(4'b1111, 7'h7F, 1'b0, 1'b0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
